// File: rtl/fault_pkg.sv
// Shared types and constants for the fault window controller.
// Holds fault codes, the FSM state encoding and the saturating abs helper.
package fault_pkg;

  localparam logic [2:0] FAULT_NORMAL = 3'b000;
  localparam logic [2:0] FAULT1       = 3'b001;

  localparam int VC_TH_DEF = 4853;
  localparam int IC_TH_DEF = 31396;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQ     = 2'd1,
    EVAL    = 2'd2,
    TRIPPED = 2'd3
  } state_t;

  // -32768 has no positive 16-bit twin, so it saturates to full scale.
  function automatic logic [14:0] abs_sat(input logic signed [15:0] x);
    logic signed [15:0] neg;
    neg = -x;
    if (x == 16'sh8000)
      return 15'h7fff;
    else if (x < 0)
      return neg[14:0];
    else
      return x[14:0];
  endfunction

endpackage

// File: rtl/fault_window_ctrl_if.sv
// Sample stream, control and status bundle of the fault window controller.
// master drives samples/control, slave (the controller) drives status.
interface fault_window_ctrl_if;
  logic               enable;
  logic               sample_valid;
  logic signed [15:0] vc_sample;
  logic signed [15:0] ic_sample;
  logic               clear_trip;
  logic               peak_valid;
  logic signed [15:0] vc_peak;
  logic signed [15:0] ic_peak;
  logic [2:0]         fault_type;
  logic [3:0]         confirm_cnt;
  logic               trip;
  logic               overrun;
  logic               busy;

  modport master (
    output enable, sample_valid, vc_sample, ic_sample, clear_trip,
    input  peak_valid, vc_peak, ic_peak, fault_type, confirm_cnt,
           trip, overrun, busy
  );

  modport slave (
    input  enable, sample_valid, vc_sample, ic_sample, clear_trip,
    output peak_valid, vc_peak, ic_peak, fault_type, confirm_cnt,
           trip, overrun, busy
  );
endinterface

// File: rtl/fault_window_ctrl_abs_peak_tracker.sv
// Running saturated |sample| peak for one channel.
// peak_nxt exposes the value including the current sample for same-edge capture.
module abs_peak_tracker
  import fault_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               valid,
  input  logic signed [15:0] sample,
  output logic [14:0]        peak,
  output logic [14:0]        peak_nxt
);

  logic [14:0] mag;

  always_comb begin
    mag      = abs_sat(sample);
    peak_nxt = peak;
    if (valid && (mag > peak))
      peak_nxt = mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      peak <= '0;
    else if (clr)
      peak <= '0;
    else
      peak <= peak_nxt;
  end

endmodule

// File: rtl/fault_window_ctrl.sv
// Windowed Vc/Ic peak classifier with consecutive-window trip confirmation.
//   state   | meaning
//   IDLE    | waiting for enable, trackers held clear
//   ACQ     | accumulating WIN_LEN samples into running peaks
//   EVAL    | one cycle: peak_valid, confirm counter update
//   TRIPPED | trip latched until clear_trip
module fault_window_ctrl
  import fault_pkg::*;
#(
  parameter int WIN_LEN   = 16,
  parameter int CONFIRM_N = 3,
  parameter int VC_TH     = VC_TH_DEF,
  parameter int IC_TH     = IC_TH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fault_window_ctrl_if.slave   bus
);

  localparam int              CW          = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CW-1:0]   LAST_IDX    = CW'(WIN_LEN - 1);
  localparam logic [3:0]      CONFIRM_MAX = 4'(CONFIRM_N);
  localparam logic [15:0]     VC_TH16     = 16'(VC_TH);
  localparam logic [15:0]     IC_TH16     = 16'(IC_TH);

  state_t        state, state_nxt;
  logic [CW-1:0] win_cnt, win_cnt_nxt;
  logic [3:0]    cnt, cnt_nxt, cnt_inc;
  logic [14:0]   vc_run, vc_run_nxt, ic_run, ic_run_nxt;
  logic [14:0]   vc_pk, ic_pk;
  logic [2:0]    ftype;
  logic          ovr;
  logic          take, last, trk_clr, eval_fault;

  function automatic logic is_fault(input logic [14:0] v, input logic [14:0] i);
    return ({1'b0, v} > VC_TH16) && ({1'b0, i} > IC_TH16);
  endfunction

  assign take    = (state == ACQ) && bus.enable && bus.sample_valid;
  assign last    = take && (win_cnt == LAST_IDX);
  assign trk_clr = (state != ACQ) || !bus.enable;

  abs_peak_tracker u_vc_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (trk_clr),
    .valid    (take),
    .sample   (bus.vc_sample),
    .peak     (vc_run),
    .peak_nxt (vc_run_nxt)
  );

  abs_peak_tracker u_ic_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (trk_clr),
    .valid    (take),
    .sample   (bus.ic_sample),
    .peak     (ic_run),
    .peak_nxt (ic_run_nxt)
  );

  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = win_cnt;
    cnt_nxt     = cnt;
    eval_fault  = is_fault(vc_pk, ic_pk);
    cnt_inc     = (cnt >= CONFIRM_MAX) ? CONFIRM_MAX : cnt + 4'd1;

    unique case (state)
      IDLE: begin
        win_cnt_nxt = '0;
        if (bus.enable)
          state_nxt = ACQ;
      end
      ACQ: begin
        if (!bus.enable) begin
          state_nxt   = IDLE;
          win_cnt_nxt = '0;
          cnt_nxt     = '0;
        end else if (take) begin
          if (last) begin
            state_nxt   = EVAL;
            win_cnt_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + 1'b1;
          end
        end
      end
      EVAL: begin
        win_cnt_nxt = '0;
        state_nxt   = bus.enable ? ACQ : IDLE;
        if (eval_fault) begin
          cnt_nxt = cnt_inc;
          // A confirmed trip wins over a dropped enable: protection must latch.
          if (cnt_inc == CONFIRM_MAX)
            state_nxt = TRIPPED;
        end else begin
          cnt_nxt = '0;
        end
      end
      TRIPPED: begin
        if (bus.clear_trip) begin
          cnt_nxt   = '0;
          state_nxt = bus.enable ? ACQ : IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        win_cnt_nxt = '0;
        cnt_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      win_cnt <= '0;
      cnt     <= '0;
      vc_pk   <= '0;
      ic_pk   <= '0;
      ftype   <= FAULT_NORMAL;
      ovr     <= 1'b0;
    end else begin
      state   <= state_nxt;
      win_cnt <= win_cnt_nxt;
      cnt     <= cnt_nxt;
      if (last) begin
        vc_pk <= vc_run_nxt;
        ic_pk <= ic_run_nxt;
        ftype <= is_fault(vc_run_nxt, ic_run_nxt) ? FAULT1 : FAULT_NORMAL;
      end
      // A sample landing in the same cycle as the clear still counts as overrun.
      if (bus.sample_valid && ((state == EVAL) || (state == TRIPPED)))
        ovr <= 1'b1;
      else if (bus.clear_trip)
        ovr <= 1'b0;
    end
  end

  assign bus.peak_valid  = (state == EVAL);
  assign bus.vc_peak     = {1'b0, vc_pk};
  assign bus.ic_peak     = {1'b0, ic_pk};
  assign bus.fault_type  = ftype;
  assign bus.confirm_cnt = cnt;
  assign bus.trip        = (state == TRIPPED);
  assign bus.overrun     = ovr;
  assign bus.busy        = (state == ACQ) || (state == EVAL);

endmodule

// File: tb/tb_fault_window_ctrl.sv
// Bench for fault_window_ctrl with WIN_LEN=4; dut0 uses CONFIRM_N=2, dut1 CONFIRM_N=1.
// Window results go through a scoreboard queue popped on peak_valid.
module tb_fault_window_ctrl;
  import fault_pkg::*;

  localparam int WL = 4;

  typedef struct {
    logic [15:0] vc;
    logic [15:0] ic;
    logic [2:0]  ft;
  } exp_t;

  typedef struct {
    logic               sel;
    logic signed [15:0] vc;
    logic signed [15:0] ic;
    logic [15:0]        evc;
    logic [15:0]        eic;
    logic [2:0]         eft;
    logic [3:0]         ecnt;
    logic               etrip;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               enable = 1'b0, sample_valid = 1'b0, clear_trip = 1'b0;
  logic signed [15:0] vc_s = '0, ic_s = '0;
  logic               sel = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];

  fault_window_ctrl_if b0();
  fault_window_ctrl_if b1();

  assign b0.enable = enable;  assign b0.sample_valid = sample_valid;
  assign b0.vc_sample = vc_s; assign b0.ic_sample = ic_s;
  assign b0.clear_trip = clear_trip;
  assign b1.enable = enable;  assign b1.sample_valid = sample_valid;
  assign b1.vc_sample = vc_s; assign b1.ic_sample = ic_s;
  assign b1.clear_trip = clear_trip;

  fault_window_ctrl #(.WIN_LEN(WL), .CONFIRM_N(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fault_window_ctrl #(.WIN_LEN(WL), .CONFIRM_N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic        pv, trp, ovr, bsy;
  logic [15:0] vpk, ipk;
  logic [2:0]  ft;
  logic [3:0]  cc;

  always_comb begin
    pv  = sel ? b1.peak_valid  : b0.peak_valid;
    trp = sel ? b1.trip        : b0.trip;
    ovr = sel ? b1.overrun     : b0.overrun;
    bsy = sel ? b1.busy        : b0.busy;
    vpk = sel ? b1.vc_peak     : b0.vc_peak;
    ipk = sel ? b1.ic_peak     : b0.ic_peak;
    ft  = sel ? b1.fault_type  : b0.fault_type;
    cc  = sel ? b1.confirm_cnt : b0.confirm_cnt;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int abs_m(input logic signed [15:0] x);
    if (x == -16'sd32768) return 32767;
    return (x < 0) ? -int'(x) : int'(x);
  endfunction

  function automatic exp_t model_exp(input logic [3:0][15:0] vcs, input logic [3:0][15:0] ics);
    int mv = 0, mi = 0;
    exp_t e;
    for (int i = 0; i < WL; i++) begin
      if (abs_m(vcs[i]) > mv) mv = abs_m(vcs[i]);
      if (abs_m(ics[i]) > mi) mi = abs_m(ics[i]);
    end
    e.vc = 16'(mv);
    e.ic = 16'(mi);
    e.ft = (mv > 4853 && mi > 31396) ? 3'b001 : 3'b000;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && pv) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_peak_valid: got 1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_vc_peak", vpk, e.vc);
        check("sb_ic_peak", ipk, e.ic);
        check("sb_fault_type", ft, e.ft);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; clear_trip = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic start();
    @(posedge clk); #1;
    enable = 1'b1;
  endtask

  task automatic send_window(input logic [3:0][15:0] vcs, input logic [3:0][15:0] ics, input exp_t e);
    for (int i = 0; i < WL; i++) begin
      @(posedge clk); #1;
      sample_valid = 1'b1;
      vc_s = vcs[i];
      ic_s = ics[i];
      if (i == WL - 1) q.push_back(e);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic model_window(input logic [3:0][15:0] vcs, input logic [3:0][15:0] ics);
    send_window(vcs, ics, model_exp(vcs, ics));
  endtask

  task automatic post_window(input string nm, input logic [3:0] ecnt, input logic etrip);
    @(posedge clk); #1;
    check({nm, "_pv_seen"}, q.size(), 0);
    check({nm, "_cnt"}, cc, ecnt);
    check({nm, "_trip"}, trp, etrip);
  endtask

  vec_t tbl[6];
  localparam logic [3:0][15:0] FV = {4{16'sd5000}};
  localparam logic [3:0][15:0] FI = {4{16'sd32000}};
  localparam logic [3:0][15:0] NV = {4{16'sd1000}};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 16'sd1000,   -16'sd1200,  16'd1000,  16'd1200,  3'd0, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 16'sd4853,   16'sd32000,  16'd4853,  16'd32000, 3'd0, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 16'sd4854,   16'sd31396,  16'd4854,  16'd31396, 3'd0, 4'd0, 1'b0};
    tbl[3] = '{1'b1, 16'sd4854,   16'sd31397,  16'd4854,  16'd31397, 3'd1, 4'd1, 1'b1};
    tbl[4] = '{1'b0, 16'sh8000,   -16'sd32000, 16'd32767, 16'd32000, 3'd1, 4'd1, 1'b0};
    tbl[5] = '{1'b0, 16'sd0,      -16'sd32767, 16'd0,     16'd32767, 3'd0, 4'd0, 1'b0};

    // reset state
    do_reset();
    check("rst_peak_valid", pv, 0);
    check("rst_vc_peak", vpk, 0);
    check("rst_ic_peak", ipk, 0);
    check("rst_fault_type", ft, 0);
    check("rst_cnt", cc, 0);
    check("rst_trip", trp, 0);
    check("rst_overrun", ovr, 0);
    check("rst_busy", bsy, 0);

    // table rows: one constant window each, from reset
    for (int r = 0; r < 6; r++) begin
      exp_t e;
      do_reset();
      sel = tbl[r].sel;
      e.vc = tbl[r].evc; e.ic = tbl[r].eic; e.ft = tbl[r].eft;
      start();
      send_window({4{tbl[r].vc}}, {4{tbl[r].ic}}, e);
      post_window($sformatf("row%0d", r), tbl[r].ecnt, tbl[r].etrip);
    end
    sel = 1'b0;

    // trip confirm, overrun, clear
    do_reset();
    start();
    model_window(FV, FI);
    post_window("trip_w1", 1, 0);
    check("trip_w1_ft", ft, 1);
    check("trip_w1_busy", bsy, 1);
    model_window(FV, FI);
    post_window("trip_w2", 2, 1);
    check("trip_busy", bsy, 0);
    @(posedge clk); #1; sample_valid = 1'b1;
    @(posedge clk); #1; sample_valid = 1'b0;
    check("trip_overrun", ovr, 1);
    check("trip_hold", trp, 1);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("trip_hold_no_en", trp, 1);
    clear_trip = 1'b1;
    @(posedge clk); #1; clear_trip = 1'b0;
    check("clr_trip", trp, 0);
    check("clr_overrun", ovr, 0);
    check("clr_cnt", cc, 0);
    check("clr_busy", bsy, 0);

    // non-consecutive faults, then a mixed-sign window
    do_reset();
    start();
    model_window(FV, FI);
    post_window("nc_f1", 1, 0);
    model_window(NV, NV);
    post_window("nc_n", 0, 0);
    model_window(FV, FI);
    post_window("nc_f2", 1, 0);
    model_window({16'sd50, 16'sd300, -16'sd6000, 16'sd100},
                 {16'sd40, -16'sd30, 16'sd20, 16'sd10});
    post_window("mixed", 0, 0);
    check("mixed_vc_peak", vpk, 6000);

    // abort after two samples: outputs hold, count clears, fresh window after
    model_window(FV, FI);
    post_window("ab_f", 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      sample_valid = 1'b1; vc_s = 16'sd9000; ic_s = 16'sd32500;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", bsy, 0);
    check("abort_cnt", cc, 0);
    check("abort_hold_vc", vpk, 5000);
    check("abort_no_pv", q.size(), 0);
    enable = 1'b1;
    model_window({4{16'sd2000}}, {4{16'sd100}});
    post_window("reacq", 0, 0);

    // async reset mid-acquisition
    model_window(FV, FI);
    post_window("ar_f", 1, 0);
    @(posedge clk); #1; sample_valid = 1'b1; vc_s = 16'sd7000; ic_s = 16'sd7000;
    @(posedge clk); #1; sample_valid = 1'b0;
    check("ar_pre_vc", vpk, 5000);
    check("ar_pre_busy", bsy, 1);
    #2; rst_n = 1'b0;
    #1;
    check("ar_vc_peak", vpk, 0);
    check("ar_ic_peak", ipk, 0);
    check("ar_fault_type", ft, 0);
    check("ar_cnt", cc, 0);
    check("ar_trip", trp, 0);
    check("ar_overrun", ovr, 0);
    check("ar_busy", bsy, 0);
    check("ar_pv", pv, 0);
    enable = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fault_window_ctrl.md
Name: fault_window_ctrl

Overview:
- Sequences fault classification over fixed sample windows.
- Acquires streaming Vc/Ic samples and tracks the per-window absolute peak of each channel.
- At window end, applies the frozen decision-tree rule. A fault is declared only after CONFIRM_N consecutive faulty windows; the controller then latches a trip until software clears it.
- Sits between the ADC sample stream and the protection/relay interface.

Parameters:
- WIN_LEN, 16, samples per window (>=2)
- CONFIRM_N, 3, consecutive faulty windows required to trip (1..15)
- VC_TH, 4853, Vc peak threshold; fault requires vc_peak > VC_TH
- IC_TH, 31396, Ic peak threshold; fault requires ic_peak > IC_TH

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run acquisition; low aborts the current window
- sample_valid  in  1  vc_sample/ic_sample valid this cycle
- vc_sample  in  16  signed Vc sample
- ic_sample  in  16  signed Ic sample
- clear_trip  in  1  pulse; releases the trip latch and clears overrun
- peak_valid  out  1  one-cycle pulse; peaks/fault_type updated
- vc_peak  out  16  signed, last window's |Vc| peak (always >=0)
- ic_peak  out  16  signed, last window's |Ic| peak (always >=0)
- fault_type  out  3  3'b000 NORMAL, 3'b001 FAULT1; others reserved
- confirm_cnt  out  4  current consecutive-fault count
- trip  out  1  latched trip
- overrun  out  1  sticky; a sample arrived in EVAL or TRIPPED
- busy  out  1  state is ACQ or EVAL

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE
  - all outputs 0
  - window counter, running peaks and confirm_cnt cleared
- Abs rule: |x| = x>=0 ? x : -x, with -32768 saturating to 32767. Peaks are compared unsigned on 15 bits.
- States:
  - IDLE: enable=1 -> ACQ (running peaks=0, win_cnt=0).
  - ACQ:
    - Each sample_valid: running peak = max(running peak, |sample|) per channel; win_cnt++.
    - Sample with win_cnt==WIN_LEN-1 -> EVAL. The peaks including that sample are registered into vc_peak/ic_peak and fault_type at the same edge.
    - enable=0 -> IDLE. Partial window discarded, confirm_cnt=0, outputs hold.
  - EVAL (exactly 1 cycle):
    - peak_valid=1.
    - fault = (vc_peak > VC_TH) && (ic_peak > IC_TH); fault_type reflects it.
    - On fault: confirm_cnt+1; if the new value == CONFIRM_N -> TRIPPED, else -> ACQ.
    - On no fault: confirm_cnt=0 -> ACQ.
    - Running peaks and win_cnt clear on exit.
    - sample_valid in EVAL: sample ignored, overrun=1.
  - TRIPPED:
    - trip=1; no acquisition; sample_valid sets overrun.
    - clear_trip -> trip=0, confirm_cnt=0, next state ACQ if enable else IDLE.
- Comparison rule is strict greater-than on both thresholds (vc_peak==VC_TH is NORMAL).
- clear_trip in any state clears overrun. Outside TRIPPED it does nothing else.
- enable=0 in EVAL: EVAL completes (peak_valid pulses), then -> IDLE; confirm_cnt is still updated.
- enable=0 in TRIPPED: trip holds until clear_trip.
- Latency: peak_valid is asserted on the cycle after the clock edge that accepts the WIN_LEN-th sample. trip rises on the cycle after the confirming EVAL.
- confirm_cnt saturates at CONFIRM_N; it never wraps.

Decomposition:
- Shared package (fault_pkg): fault code constants FAULT_NORMAL=3'b000 and FAULT1=3'b001, the state enum, and default thresholds VC_TH_DEF=4853 and IC_TH_DEF=31396.
- One natural sub-module: abs_peak_tracker, one per channel.
  - Inputs: clk, rst_n, clr, valid, signed sample.
  - Output: saturated running |peak|.
- The FSM, confirm counter and classification compare stay in the top level.

Test Plan (WIN_LEN=4, CONFIRM_N=2 unless noted):
1. Normal window: 4 samples, vc=1000, ic=-1200 -> peak_valid the cycle after the 4th sample; vc_peak=1000, ic_peak=1200, fault_type=0, trip=0.
2. Trip confirm: two windows each containing vc=5000, ic=32000 -> window 1 gives fault_type=1, confirm_cnt=1, trip=0; window 2 gives confirm_cnt=2, and trip=1 the next cycle. Further samples set overrun; clear_trip gives trip=0 and overrun=0.
3. Threshold boundaries (CONFIRM_N=1):
   - vc=4853, ic=32000 -> 0
   - vc=4854, ic=31396 -> 0
   - vc=4854, ic=31397 -> 1
4. Abs/saturation: vc=-32768, ic=-32000 -> vc_peak=32767, ic_peak=32000, fault_type=1. Mixed window [100, -6000, 300, 50] gives a Vc peak of 6000.
5. Non-consecutive: fault, normal, fault windows -> confirm_cnt goes 1, 0, 1; trip stays 0.
6. Abort cases:
   - enable dropped after 2 samples -> IDLE, no peak_valid, confirm_cnt=0; re-enable and the next window counts a fresh 4 samples.
   - rst_n asserted mid-ACQ -> all outputs 0 immediately, asynchronously.
